// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM encoding, BCD limits and seven-segment constants
package bcd_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DIGIT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [6:0] SEG0 = 7'b100_0000;
  localparam logic [6:0] SEG1 = 7'b111_1001;
  localparam logic [6:0] SEG2 = 7'b010_0100;
  localparam logic [6:0] SEG3 = 7'b011_0000;
  localparam logic [6:0] SEG4 = 7'b001_1001;
  localparam logic [6:0] SEG5 = 7'b001_0010;
  localparam logic [6:0] SEG6 = 7'b000_0010;
  localparam logic [6:0] SEG7 = 7'b111_1000;
  localparam logic [6:0] SEG8 = 7'b000_0000;
  localparam logic [6:0] SEG9 = 7'b001_0000;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;
  function automatic logic bcd_bad(input logic [3:0] n);
    return n > BCD_MAX_DIGIT;
  endfunction
endpackage

// File: rtl/bcd_digit_alu.sv
// bcd_digit_alu: one-digit BCD add/subtract cell with carry/borrow
module bcd_digit_alu
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       op,
  output logic [3:0] digit,
  output logic       cout
);
  logic [4:0] s;
  logic [4:0] d;
  // 5-bit sum/difference; bit 4 of the difference flags a borrow
  always_comb begin
    s = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    d = {1'b0, a} - {1'b0, b} - {4'b0, cin};
    cout = op ? d[4] : (s > {1'b0, BCD_MAX_DIGIT});
    digit = op ? (d[4] ? 4'(d + 5'd10) : d[3:0])
               : ((s > {1'b0, BCD_MAX_DIGIT}) ? 4'(s - 5'd10) : s[3:0]);
  end
endmodule

// File: rtl/bcd_serial_alu_ctrl.sv
// bcd_serial_alu_ctrl: digit-serial BCD add/sub sequencer (optional BCD_ACCUMULATE_EN running total)
module bcd_serial_alu_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  START_N,
  input  logic                  OP,
  input  logic [4*DIGITS-1:0]   A_BCD,
  input  logic [4*DIGITS-1:0]   B_BCD,
  output logic [4*DIGITS-1:0]   RESULT_BCD,
  output logic                  OVF,
  output logic                  ERR,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  VALID
);
  localparam logic [1:0] LAST = 2'(DIGITS - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   start_pulse;
  logic [1:0]             state;
  logic [1:0]             idx;
  logic                   carry;
  logic                   op_q;
  logic [4*DIGITS-1:0]    a_q;
  logic [4*DIGITS-1:0]    b_q;
  logic [4*DIGITS-1:0]    a_src;
  logic                   bad;
  logic [3:0]             digit;
  logic                   cout;
`ifdef BCD_ACCUMULATE_EN
  assign a_src = (VALID && !OVF && !ERR) ? RESULT_BCD : A_BCD;
`else
  assign a_src = A_BCD;
`endif
  assign start_pulse = prev & ~sync[SYNC_STAGES-1];
  assign BUSY = (state == S_LOAD) || (state == S_DIGIT);
  assign DONE = state == S_DONE;
  // flag any non-decimal nibble among the operands about to be loaded
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bad = bad | bcd_bad(a_src[i*4 +: 4]) | bcd_bad(B_BCD[i*4 +: 4]);
  end
  bcd_digit_alu u_alu (
    .a(a_q[idx*4 +: 4]),
    .b(b_q[idx*4 +: 4]),
    .cin(carry),
    .op(op_q),
    .digit(digit),
    .cout(cout)
  );
  // button synchroniser; reset to the released level so leaving reset never fakes a press
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], START_N};
      prev <= sync[SYNC_STAGES-1];
    end
  end
  // sequencer: load operands, one digit per clock, final flags land with the DONE cycle
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_IDLE;
      idx <= '0;
      carry <= 1'b0;
      op_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      RESULT_BCD <= '0;
      OVF <= 1'b0;
      ERR <= 1'b0;
      VALID <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start_pulse) state <= S_LOAD;
        S_LOAD: begin
          a_q <= a_src;
          b_q <= B_BCD;
          op_q <= OP;
          ERR <= bad;
          carry <= 1'b0;
          VALID <= 1'b0;
          idx <= '0;
          state <= S_DIGIT;
        end
        S_DIGIT: begin
          RESULT_BCD[idx*4 +: 4] <= digit;
          carry <= cout;
          idx <= idx + 2'd1;
          if (idx == LAST) begin
            state <= S_DONE;
            OVF <= cout;
            VALID <= 1'b1;
            if (cout || ERR) RESULT_BCD <= '1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
